// File: rtl/us_ranger_pkg.sv
// Shared types and constants for the ultrasonic ranger front-end.
package us_ranger_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TRIG,
    WAIT_ECHO,
    MEASURE,
    HOLDOFF
  } state_t;

  // Wide all-ones code; users slice it down to their distance width.
  localparam logic [63:0] DIST_SAT = '1;

  // Depth of the optional moving-average filter.
  localparam int FILTER_TAPS = 4;

endpackage

// File: rtl/us_ranger_frontend_echo_sync.sv
// Two-flop synchronizer for the sensor echo pin with rise/fall pulses.
module echo_sync (
  input  logic clk,
  input  logic rstn,
  input  logic echo_in,
  output logic echo_s,
  output logic echo_rise,
  output logic echo_fall
);

  logic echo_meta;
  logic echo_d;

  // Synchronizer chain plus one delay stage for edge detection.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      echo_meta <= 1'b0;
      echo_s    <= 1'b0;
      echo_d    <= 1'b0;
    end else begin
      echo_meta <= echo_in;
      echo_s    <= echo_meta;
      echo_d    <= echo_s;
    end
  end

  assign echo_rise = echo_s & ~echo_d;
  assign echo_fall = ~echo_s & echo_d;

endmodule

// File: rtl/us_ranger_frontend.sv
// Ultrasonic ranger front-end: trigger, echo timing, timeout, holdoff.
// Optional macro US_RANGER_AVG_FILTER_EN adds a 4-tap mean on dist_v.
module us_ranger_frontend
  import us_ranger_pkg::*;
#(
  parameter int DATA_OUT_WIDTH  = 16,
  parameter int TRIG_CYCLES     = 10,
  parameter int CYCLES_PER_UNIT = 58,
  parameter int TIMEOUT_CYCLES  = 30000,
  parameter int HOLDOFF_CYCLES  = 60000
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      enable,
  input  logic                      echo_in,
  output logic                      trig_out,
  output logic [DATA_OUT_WIDTH-1:0] dist_v,
  output logic                      dist_valid,
  output logic                      timeout_err,
  output logic                      busy
);

  localparam int TRW = $clog2(TRIG_CYCLES + 1);
  localparam int PSW = $clog2(CYCLES_PER_UNIT + 1);
  localparam int TOW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int HOW = $clog2(HOLDOFF_CYCLES + 1);

  localparam logic [TRW-1:0] TRIG_LAST = TRW'(TRIG_CYCLES - 1);
  localparam logic [PSW-1:0] PS_LAST   = PSW'(CYCLES_PER_UNIT - 1);
  localparam logic [TOW-1:0] TO_LAST   = TOW'(TIMEOUT_CYCLES - 1);
  localparam logic [HOW-1:0] HO_LAST   = HOW'(HOLDOFF_CYCLES - 1);
  localparam logic [DATA_OUT_WIDTH-1:0] SAT = DIST_SAT[DATA_OUT_WIDTH-1:0];

  state_t state, state_n;

  logic [TRW-1:0]            trig_cnt;
  logic [PSW-1:0]            presc;
  logic [TOW-1:0]            tcnt;
  logic [HOW-1:0]            hold_cnt;
  logic [DATA_OUT_WIDTH-1:0] dist_cnt;

  logic echo_s, echo_rise, echo_fall;

  logic                      res_valid;
  logic                      res_timeout;
  logic [DATA_OUT_WIDTH-1:0] res_dist;

  echo_sync u_echo_sync (
    .clk       (clk),
    .rstn      (rstn),
    .echo_in   (echo_in),
    .echo_s    (echo_s),
    .echo_rise (echo_rise),
    .echo_fall (echo_fall)
  );

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_n;
  end

  // Next-state and result selection; an echo fall beats a same-cycle timeout.
  always_comb begin
    state_n     = state;
    res_valid   = 1'b0;
    res_timeout = 1'b0;
    res_dist    = dist_cnt;
    unique case (state)
      IDLE:      if (enable) state_n = TRIG;
      TRIG:      if (trig_cnt == TRIG_LAST) state_n = WAIT_ECHO;
      WAIT_ECHO: begin
        if (tcnt == TO_LAST) begin
          res_valid   = 1'b1;
          res_timeout = 1'b1;
          res_dist    = SAT;
          state_n     = HOLDOFF;
        end else if (echo_rise) begin
          state_n = MEASURE;
        end
      end
      MEASURE: begin
        if (echo_fall) begin
          res_valid = 1'b1;
          state_n   = HOLDOFF;
        end else if (tcnt == TO_LAST) begin
          res_valid   = 1'b1;
          res_timeout = 1'b1;
          res_dist    = SAT;
          state_n     = HOLDOFF;
        end
      end
      HOLDOFF:   if (hold_cnt == HO_LAST) state_n = IDLE;
      default:   state_n = IDLE;
    endcase
  end

  // Per-state counters and the distance prescaler; the rise cycle itself is
  // an echo-high cycle, so it is folded into the counts on entry to MEASURE.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      trig_cnt <= '0;
      presc    <= '0;
      tcnt     <= '0;
      hold_cnt <= '0;
      dist_cnt <= '0;
    end else begin
      trig_cnt <= (state == TRIG)    ? trig_cnt + 1'b1 : '0;
      hold_cnt <= (state == HOLDOFF) ? hold_cnt + 1'b1 : '0;
      tcnt     <= (state == WAIT_ECHO || state == MEASURE) ? tcnt + 1'b1 : '0;
      if (state == WAIT_ECHO && state_n == MEASURE) begin
        presc    <= (PS_LAST == '0) ? '0 : PSW'(1);
        dist_cnt <= (PS_LAST == '0) ? DATA_OUT_WIDTH'(1) : '0;
      end else if (state == MEASURE && echo_s) begin
        if (presc == PS_LAST) begin
          presc <= '0;
          if (dist_cnt != SAT) dist_cnt <= dist_cnt + 1'b1;
        end else begin
          presc <= presc + 1'b1;
        end
      end
    end
  end

  // Registered trigger, high exactly while the FSM sits in TRIG.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) trig_out <= 1'b0;
    else       trig_out <= (state_n == TRIG);
  end

  assign busy = (state != IDLE);

`ifdef US_RANGER_AVG_FILTER_EN
  logic [DATA_OUT_WIDTH-1:0] taps [FILTER_TAPS];
  logic                      primed;
  logic                      pend_valid;
  logic                      pend_timeout;
  logic [DATA_OUT_WIDTH+1:0] tap_sum;

  // Tap history; the first good sample after reset fills every tap.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < FILTER_TAPS; i++) taps[i] <= '0;
      primed       <= 1'b0;
      pend_valid   <= 1'b0;
      pend_timeout <= 1'b0;
    end else begin
      pend_valid   <= res_valid;
      pend_timeout <= res_timeout;
      if (res_valid && !res_timeout) begin
        primed <= 1'b1;
        for (int i = 0; i < FILTER_TAPS; i++) begin
          if (!primed || i == FILTER_TAPS - 1) taps[i] <= res_dist;
          else                                 taps[i] <= taps[i+1];
        end
      end
    end
  end

  // Sum of the taps with two guard bits so four full-scale samples fit.
  always_comb begin
    tap_sum = '0;
    for (int i = 0; i < FILTER_TAPS; i++) tap_sum = tap_sum + {2'b00, taps[i]};
  end

  // Publish the mean one cycle after the taps settle; timeouts bypass it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dist_v      <= '0;
      timeout_err <= 1'b0;
      dist_valid  <= 1'b0;
    end else begin
      dist_valid <= pend_valid;
      if (pend_valid) begin
        dist_v      <= pend_timeout ? SAT : tap_sum[DATA_OUT_WIDTH+1:2];
        timeout_err <= pend_timeout;
      end
    end
  end
`else
  // Publish the raw count (or the timeout code) on the result edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dist_v      <= '0;
      timeout_err <= 1'b0;
      dist_valid  <= 1'b0;
    end else begin
      dist_valid <= res_valid;
      if (res_valid) begin
        dist_v      <= res_dist;
        timeout_err <= res_timeout;
      end
    end
  end
`endif

endmodule

// File: tb/tb_us_ranger_frontend.sv
// Directed testbench for us_ranger_frontend (both macro builds).
`timescale 1ns/1ps
module tb_us_ranger_frontend;

`ifdef US_RANGER_AVG_FILTER_EN
  localparam int RES_LAT = 4;
`else
  localparam int RES_LAT = 3;
`endif
  localparam int EXTRA = RES_LAT - 3;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        enable = 1'b0, echo_in = 1'b0;
  logic        trig_out, dist_valid, timeout_err, busy;
  logic [15:0] dist_v;
  logic        enable2 = 1'b0, echo2 = 1'b0;
  logic        trig2, dist_valid2, timeout_err2, busy2;
  logic [3:0]  dist_v2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  us_ranger_frontend #(
    .DATA_OUT_WIDTH(16), .TRIG_CYCLES(4), .CYCLES_PER_UNIT(3),
    .TIMEOUT_CYCLES(200), .HOLDOFF_CYCLES(20)
  ) dut (
    .clk(clk), .rstn(rstn), .enable(enable), .echo_in(echo_in),
    .trig_out(trig_out), .dist_v(dist_v), .dist_valid(dist_valid),
    .timeout_err(timeout_err), .busy(busy)
  );

  us_ranger_frontend #(
    .DATA_OUT_WIDTH(4), .TRIG_CYCLES(4), .CYCLES_PER_UNIT(1),
    .TIMEOUT_CYCLES(200), .HOLDOFF_CYCLES(20)
  ) dut_sat (
    .clk(clk), .rstn(rstn), .enable(enable2), .echo_in(echo2),
    .trig_out(trig2), .dist_v(dist_v2), .dist_valid(dist_valid2),
    .timeout_err(timeout_err2), .busy(busy2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0; enable = 1'b0; echo_in = 1'b0; enable2 = 1'b0; echo2 = 1'b0;
    tick(); tick();
    rstn = 1'b1;
  endtask

  // Waits for a trigger pulse, returns its width; returns with trig_out low.
  task automatic wait_trig_shot(output int width, output bit seen);
    width = 0; seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      if (trig_out) seen = 1'b1;
      else tick();
    end
    while (seen && trig_out && width < 50) begin
      tick();
      width++;
    end
  endtask

  task automatic wait_valid(input int max, output int ticks, output bit seen);
    ticks = 0; seen = 1'b0;
    for (int i = 1; i <= max && !seen; i++) begin
      tick();
      if (dist_valid) begin seen = 1'b1; ticks = i; end
    end
  endtask

  task automatic test_reset();
    int n;
    rstn = 1'b0; enable = 1'b0; echo_in = 1'b0;
    #2;
    checks++; if (trig_out !== 1'b0) begin errors++; $display("[TB] FAIL reset_trig got %b expected 0", trig_out); end
    checks++; if (dist_v !== 16'h0) begin errors++; $display("[TB] FAIL reset_dist got %h expected 0000", dist_v); end
    checks++; if (dist_valid !== 1'b0 || timeout_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_flags got %b%b expected 00", dist_valid, timeout_err); end
    checks++; if (busy !== 1'b0 || busy2 !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b%b expected 00", busy, busy2); end
    checks++; if (dist_v2 !== 4'h0) begin errors++; $display("[TB] FAIL reset_dist2 got %h expected 0", dist_v2); end
    tick(); rstn = 1'b1;
    n = 0;
    for (int i = 0; i < 10; i++) begin tick(); if (busy || trig_out) n++; end
    checks++; if (n !== 0) begin errors++; $display("[TB] FAIL idle_disabled got %0d active cycles expected 0", n); end
  endtask

  task automatic test_basic_shot();
    int w, t, n; bit ok;
    do_reset();
    enable = 1'b1;
    wait_trig_shot(w, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL basic_trig_seen got 0 expected 1"); end
    checks++; if (w !== 4) begin errors++; $display("[TB] FAIL basic_trig_width got %0d expected 4", w); end
    repeat (9) tick();
    echo_in = 1'b1;
    repeat (30) tick();
    echo_in = 1'b0;
    enable = 1'b0;
    wait_valid(20, t, ok);
    checks++; if (!ok || t !== RES_LAT) begin errors++; $display("[TB] FAIL basic_latency got %0d expected %0d", t, RES_LAT); end
    checks++; if (dist_v !== 16'd10) begin errors++; $display("[TB] FAIL basic_dist got %0d expected 10", dist_v); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("[TB] FAIL basic_timeout_err got %b expected 0", timeout_err); end
    n = 0;
    for (int i = 0; i < 30; i++) begin tick(); if (dist_valid) n++; end
    checks++; if (n !== 0 || dist_v !== 16'd10) begin errors++; $display("[TB] FAIL basic_strobe_once got %0d extra strobes dist %0d expected 0 and 10", n, dist_v); end
  endtask

  task automatic test_no_echo();
    int w, t, k; bit ok;
    do_reset();
    enable = 1'b1;
    wait_trig_shot(w, ok);
    checks++; if (!ok || w !== 4) begin errors++; $display("[TB] FAIL noecho_trig got %0d expected 4", w); end
    wait_valid(300, t, ok);
    checks++; if (!ok || t !== 200 + EXTRA) begin errors++; $display("[TB] FAIL noecho_latency got %0d expected %0d", t, 200 + EXTRA); end
    checks++; if (dist_v !== 16'hFFFF) begin errors++; $display("[TB] FAIL noecho_dist got %h expected FFFF", dist_v); end
    checks++; if (timeout_err !== 1'b1) begin errors++; $display("[TB] FAIL noecho_timeout_err got %b expected 1", timeout_err); end
    k = 0;
    while (!trig_out && k < 100) begin tick(); k++; end
    checks++; if (k !== 21 - EXTRA) begin errors++; $display("[TB] FAIL noecho_retrigger got %0d expected %0d", k, 21 - EXTRA); end
    checks++; if (timeout_err !== 1'b1) begin errors++; $display("[TB] FAIL noecho_err_held got %b expected 1", timeout_err); end
    enable = 1'b0;
  endtask

  task automatic test_stuck_high();
    int w, t; bit ok;
    do_reset();
    echo_in = 1'b1;
    repeat (3) tick();
    enable = 1'b1;
    wait_trig_shot(w, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL stuck_trig_seen got 0 expected 1"); end
    enable = 1'b0;
    wait_valid(300, t, ok);
    checks++; if (!ok || t !== 200 + EXTRA) begin errors++; $display("[TB] FAIL stuck_latency got %0d expected %0d", t, 200 + EXTRA); end
    checks++; if (dist_v !== 16'hFFFF || timeout_err !== 1'b1) begin errors++; $display("[TB] FAIL stuck_result got %h/%b expected FFFF/1", dist_v, timeout_err); end
    echo_in = 1'b0;
  endtask

  task automatic test_saturation();
    int k, t;
    do_reset();
    enable2 = 1'b1;
    k = 0;
    while (!trig2 && k < 100) begin tick(); k++; end
    while (trig2 && k < 200) begin tick(); k++; end
    enable2 = 1'b0;
    checks++; if (k >= 100) begin errors++; $display("[TB] FAIL sat_trig got %0d cycles expected under 100", k); end
    repeat (2) tick();
    echo2 = 1'b1;
    repeat (40) tick();
    echo2 = 1'b0;
    t = 0;
    for (int i = 1; i <= 20 && t == 0; i++) begin tick(); if (dist_valid2) t = i; end
    checks++; if (t !== RES_LAT) begin errors++; $display("[TB] FAIL sat_latency got %0d expected %0d", t, RES_LAT); end
    checks++; if (dist_v2 !== 4'hF) begin errors++; $display("[TB] FAIL sat_dist got %h expected F", dist_v2); end
    checks++; if (timeout_err2 !== 1'b0) begin errors++; $display("[TB] FAIL sat_timeout_err got %b expected 0", timeout_err2); end
  endtask

  task automatic test_enable_drop_reset();
    int w, t, n; bit ok;
    do_reset();
    enable = 1'b1;
    wait_trig_shot(w, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL drop_trig_seen got 0 expected 1"); end
    repeat (2) tick();
    echo_in = 1'b1;
    repeat (4) tick();
    enable = 1'b0;
    repeat (5) tick();
    echo_in = 1'b0;
    wait_valid(20, t, ok);
    checks++; if (!ok || t !== RES_LAT) begin errors++; $display("[TB] FAIL drop_latency got %0d expected %0d", t, RES_LAT); end
    checks++; if (dist_v !== 16'd3 || timeout_err !== 1'b0) begin errors++; $display("[TB] FAIL drop_result got %0d/%b expected 3/0", dist_v, timeout_err); end
    repeat (19 - EXTRA) tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL drop_busy_holdoff got %b expected 1", busy); end
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL drop_busy_idle got %b expected 0", busy); end
    n = 0;
    for (int i = 0; i < 40; i++) begin tick(); if (trig_out || busy) n++; end
    checks++; if (n !== 0) begin errors++; $display("[TB] FAIL drop_parked got %0d active cycles expected 0", n); end
    enable = 1'b1;
    tick();
    checks++; if (trig_out !== 1'b1) begin errors++; $display("[TB] FAIL rearm_trig got %b expected 1", trig_out); end
    tick();
    #2 rstn = 1'b0;
    #1;
    checks++; if (trig_out !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL async_reset_ctrl got %b%b expected 00", trig_out, busy); end
    checks++; if (dist_v !== 16'h0 || timeout_err !== 1'b0 || dist_valid !== 1'b0) begin errors++; $display("[TB] FAIL async_reset_result got %h/%b/%b expected 0000/0/0", dist_v, timeout_err, dist_valid); end
    enable = 1'b0;
    tick();
    rstn = 1'b1;
  endtask

`ifdef US_RANGER_AVG_FILTER_EN
  task automatic test_filter();
    int units [4] = '{8, 12, 16, 20};
    int expd  [4] = '{8, 9, 11, 14};
    int w, t; bit ok;
    do_reset();
    enable = 1'b1;
    for (int s = 0; s < 4; s++) begin
      if (s == 3) enable = 1'b0;
      wait_trig_shot(w, ok);
      checks++; if (!ok) begin errors++; $display("[TB] FAIL filt_trig_%0d got 0 expected 1", s); end
      repeat (2) tick();
      echo_in = 1'b1;
      repeat (3 * units[s]) tick();
      echo_in = 1'b0;
      wait_valid(20, t, ok);
      checks++; if (!ok || t !== 4) begin errors++; $display("[TB] FAIL filt_latency_%0d got %0d expected 4", s, t); end
      checks++; if (dist_v !== 16'(expd[s])) begin errors++; $display("[TB] FAIL filt_dist_%0d got %0d expected %0d", s, dist_v, expd[s]); end
    end
  endtask
`endif

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_basic_shot();
    test_no_echo();
    test_stuck_high();
    test_saturation();
    test_enable_drop_reset();
`ifdef US_RANGER_AVG_FILTER_EN
    test_filter();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
